seg7_pattern_encoder: RTL and testbench



---
 rtl/seg7_pkg.sv | 42 ++++
 rtl/seg7_sync_filter.sv | 70 +++++++
 rtl/seg7_pattern_encoder.sv | 89 ++++++++
 tb/tb_seg7_pattern_encoder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared 7-segment definitions for the display code set used by
//               decoder_7seg and seg7_pattern_encoder. Patterns are held in
//               active-low form, bit order [6:0] = g f e d c b a.
// Revision    : 1.0  initial release
// ============================================================================
package seg7_pkg;

    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_ONE   = 7'b1111001;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [1:0] CODE_D     = 2'b00;
    localparam logic [1:0] CODE_E     = 2'b01;
    localparam logic [1:0] CODE_ONE   = 2'b10;
    localparam logic [1:0] CODE_BLANK = 2'b11;

    typedef struct packed {
        logic [1:0] code;
        logic       err;
    } seg7_decode_t;

    // Reverse table lookup; unrecognised patterns report code 00 with err set.
    function automatic seg7_decode_t seg7_lookup(input logic [6:0] pat);
        seg7_decode_t r;
        r.code = CODE_D;
        r.err  = 1'b0;
        case (pat)
            SEG_D:     r.code = CODE_D;
            SEG_E:     r.code = CODE_E;
            SEG_ONE:   r.code = CODE_ONE;
            SEG_BLANK: r.code = CODE_BLANK;
            default:   r.err  = 1'b1;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_sync_filter.sv
`default_nettype none
// ============================================================================
// Module      : seg7_sync_filter
// Description : Two-flop synchroniser for an asynchronous segment bus,
//               polarity normalisation to active-low form, and a stability
//               filter that raises 'stable' while the synchronised pattern has
//               matched the candidate for STABLE_CYCLES consecutive edges.
// Ports       : clk, resetn       clock / asynchronous active-low reset
//               seg_in[6:0]       raw segment bus (g..a), asynchronous
//               stable            candidate has been held long enough
//               pattern[6:0]      candidate pattern, active-low form
// Revision    : 1.0  initial release
// ============================================================================
module seg7_sync_filter
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [6:0] seg_in,
    output logic       stable,
    output logic [6:0] pattern
);

    localparam int         CNT_W     = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    // Synchroniser reset value encodes blank in whichever polarity the bus uses.
    localparam logic [6:0] c_SYNC_RST = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [6:0]       r_sync1;
    logic [6:0]       r_sync2;
    logic [6:0]       r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic [6:0]       w_norm;
    logic             w_match;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= c_SYNC_RST;
            r_sync2 <= c_SYNC_RST;
        end else begin
            r_sync1 <= seg_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_norm  = SEG_ACTIVE_LOW ? r_sync2 : ~r_sync2;
    assign w_match = (w_norm == r_cand);

    // Any change restarts the count; a steady pattern counts up and
    // saturates so 'stable' stays asserted for as long as it is held.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cand <= SEG_BLANK;
            r_cnt  <= '0;
        end else if (!w_match) begin
            r_cand <= w_norm;
            r_cnt  <= '0;
        end else if (r_cnt != c_CNT_MAX) begin
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    assign stable  = w_match && (r_cnt == c_CNT_MAX);
    assign pattern = r_cand;

endmodule
`default_nettype wire

// File: rtl/seg7_pattern_encoder.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pattern_encoder
// Description : Recovers the 2-bit display code from a 7-segment drive
//               pattern. Each newly stable pattern is reported once over a
//               valid/ready handshake; unrecognised patterns set out_err.
// Ports       : clk, resetn        clock / asynchronous active-low reset
//               seg_in[6:0]        segment bus (g..a), asynchronous
//               out_ready          consumer accepts the pending event
//               overrun_clr        clears the sticky overrun flag
//               out_valid          event pending
//               out_code[1:0]      recovered code
//               out_err            pending event is unrecognised
//               overrun            an unconsumed event was overwritten
// Revision    : 1.0  initial release
// ============================================================================
module seg7_pattern_encoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [6:0] seg_in,
    input  logic       out_ready,
    input  logic       overrun_clr,
    output logic       out_valid,
    output logic [1:0] out_code,
    output logic       out_err,
    output logic       overrun
);

    logic         w_stable;
    logic [6:0]   w_pattern;
    logic [6:0]   r_last;
    logic         w_accept;
    logic         w_consume;
    logic         w_ovr_set;
    seg7_decode_t w_dec;

    seg7_sync_filter #(
        .STABLE_CYCLES  (STABLE_CYCLES),
        .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
    ) u_filter (
        .clk     (clk),
        .resetn  (resetn),
        .seg_in  (seg_in),
        .stable  (w_stable),
        .pattern (w_pattern)
    );

    // Only a pattern differing from the last reported one raises an event,
    // so a saturated filter does not re-report and glitches that return to
    // the previous pattern are silent.
    assign w_accept  = w_stable && (w_pattern != r_last);
    assign w_consume = out_valid && out_ready;
    assign w_ovr_set = w_accept && out_valid && !out_ready;
    assign w_dec     = seg7_lookup(w_pattern);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last    <= SEG_BLANK;
            out_valid <= 1'b0;
            out_code  <= CODE_BLANK;
            out_err   <= 1'b0;
        end else if (w_accept) begin
            r_last    <= w_pattern;
            out_valid <= 1'b1;
            out_code  <= w_dec.code;
            out_err   <= w_dec.err;
        end else if (w_consume) begin
            out_valid <= 1'b0;
        end
    end

    // Set has priority over clear so an overwrite is never lost.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overrun <= 1'b0;
        end else if (w_ovr_set) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_pattern_encoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_seg7_pattern_encoder
// Description : Self-checking bench for seg7_pattern_encoder: directed
//               scenarios followed by randomised pattern/handshake traffic,
//               compared every cycle against a behavioural reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_seg7_pattern_encoder;

    localparam int         STABLE_CYCLES = 4;
    localparam logic [6:0] P_D     = 7'b0100001;
    localparam logic [6:0] P_E     = 7'b0000110;
    localparam logic [6:0] P_ONE   = 7'b1111001;
    localparam logic [6:0] P_BLANK = 7'b1111111;
    localparam logic [6:0] P_BAD   = 7'b1010101;

    logic       clk = 1'b0;
    logic       resetn;
    logic [6:0] seg_in;
    logic       out_ready;
    logic       overrun_clr;
    logic       out_valid;
    logic [1:0] out_code;
    logic       out_err;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;

    seg7_pattern_encoder #(
        .STABLE_CYCLES  (STABLE_CYCLES),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .seg_in      (seg_in),
        .out_ready   (out_ready),
        .overrun_clr (overrun_clr),
        .out_valid   (out_valid),
        .out_code    (out_code),
        .out_err     (out_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The filter input at an edge is the bus value from two edges earlier;
    // an event fires when the last STABLE_CYCLES+1 filter inputs agree and
    // differ from the last reported pattern.
    logic [6:0] m_d1, m_d2, m_last;
    logic [6:0] m_win[$];
    logic       m_valid, m_err, m_ovr;
    logic [1:0] m_code;

    function automatic logic [2:0] ref_lookup(input logic [6:0] p);
        if (p == P_D)     return 3'b000;
        if (p == P_E)     return 3'b010;
        if (p == P_ONE)   return 3'b100;
        if (p == P_BLANK) return 3'b110;
        return 3'b001;   // {code=00, err=1}
    endfunction

    task automatic model_reset();
        m_d1 = P_BLANK; m_d2 = P_BLANK; m_last = P_BLANK;
        m_win.delete();
        for (int i = 0; i <= STABLE_CYCLES; i++) m_win.push_back(P_BLANK);
        m_valid = 1'b0; m_code = 2'b11; m_err = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic model_edge();
        logic [6:0] seen;
        logic       all_eq, acc, ovr_set;
        logic [2:0] d;
        if (!resetn) begin
            model_reset();
            return;
        end
        seen = m_d2;
        m_d2 = m_d1;
        m_d1 = seg_in;
        m_win.push_back(seen);
        while (m_win.size() > STABLE_CYCLES + 1) void'(m_win.pop_front());
        all_eq = 1'b1;
        foreach (m_win[i]) if (m_win[i] != m_win[0]) all_eq = 1'b0;
        acc     = all_eq && (seen != m_last);
        ovr_set = acc && m_valid && !out_ready;
        if (acc) begin
            d       = ref_lookup(seen);
            m_last  = seen;
            m_code  = d[2:1];
            m_err   = d[0];
            m_valid = 1'b1;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        if (ovr_set)          m_ovr = 1'b1;
        else if (overrun_clr) m_ovr = 1'b0;
    endtask

    task automatic compare_all();
        check("valid",   32'(out_valid), 32'(m_valid));
        check("code",    32'(out_code),  32'(m_code));
        check("err",     32'(out_err),   32'(m_err));
        check("overrun", 32'(overrun),   32'(m_ovr));
    endtask

    // Inputs are changed at the falling edge; outputs compared there too.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic hold(input logic [6:0] p, input int n, output int events);
        seg_in = p;
        events = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (out_valid && out_ready) events++;
        end
    endtask

    // Steps until out_valid rises (bounded) and returns the edge count.
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    int lat, ev, pulses;

    initial begin
        resetn = 1'b0; seg_in = P_BLANK; out_ready = 1'b1; overrun_clr = 1'b0;
        model_reset();
        @(negedge clk);
        step(); step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_code",  32'(out_code),  32'd3);
        check("rst_ovr",   32'(overrun),   32'd0);
        resetn = 1'b1;

        // Blank bus after reset: no event.
        hold(P_BLANK, 20, ev);
        check("blank_events", 32'(ev), 32'd0);
        check("blank_code",   32'(out_code), 32'd3);

        // 'd' reported after exactly STABLE_CYCLES+3 edges, one-cycle pulse.
        seg_in = P_D;
        wait_valid(lat);
        check("lat_d",  32'(lat), 32'(STABLE_CYCLES + 3));
        check("code_d", 32'(out_code), 32'd0);
        check("err_d",  32'(out_err),  32'd0);
        pulses = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid) pulses++;
        end
        check("pulse_d", 32'(pulses), 32'd1);

        // Short glitch to 'E' returning to 'd': silent. Then '1'.
        hold(P_E, 2, ev);
        hold(P_D, 12, ev);
        check("glitch_events", 32'(ev), 32'd0);
        out_ready = 1'b0;
        seg_in = P_ONE;
        wait_valid(lat);
        check("code_one", 32'(out_code), 32'd2);
        out_ready = 1'b1;
        step();

        // Unrecognised pattern.
        out_ready = 1'b0;
        seg_in = P_BAD;
        wait_valid(lat);
        check("bad_err",  32'(out_err),  32'd1);
        check("bad_code", 32'(out_code), 32'd0);
        out_ready = 1'b1;
        step();

        // Overrun: two acceptances without consumption.
        out_ready = 1'b0;
        hold(P_E, 10, ev);
        hold(P_ONE, 10, ev);
        check("ovr_code",  32'(out_code),  32'd2);
        check("ovr_flag",  32'(overrun),   32'd1);
        check("ovr_valid", 32'(out_valid), 32'd1);
        overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
        check("ovr_clr", 32'(overrun), 32'd0);
        out_ready = 1'b1; step();
        check("ovr_consumed", 32'(out_valid), 32'd0);
        hold(P_ONE, 5, ev);
        check("ovr_no_second", 32'(ev), 32'd0);

        // Reset while an 'E' event is pending.
        out_ready = 1'b0;
        hold(P_E, 10, ev);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        resetn = 1'b0;
        model_reset();
        #1;
        check("async_valid", 32'(out_valid), 32'd0);
        check("async_code",  32'(out_code),  32'd3);
        check("async_err",   32'(out_err),   32'd0);
        step();
        resetn = 1'b1;
        wait_valid(lat);
        check("lat_after_rst", 32'(lat), 32'(STABLE_CYCLES + 3));
        check("code_after_rst", 32'(out_code), 32'd1);
        out_ready = 1'b1;
        step();

        // Randomised traffic against the model.
        for (int c = 0; c < 400; c++) begin
            logic [6:0] p;
            int n, sel;
            sel = $urandom_range(0, 5);
            case (sel)
                0: p = P_D;
                1: p = P_E;
                2: p = P_ONE;
                3: p = P_BLANK;
                default: p = 7'($urandom);
            endcase
            n = $urandom_range(1, 12);
            seg_in = p;
            for (int i = 0; i < n; i++) begin
                out_ready   = ($urandom_range(0, 9) < 7);
                overrun_clr = ($urandom_range(0, 19) == 0);
                step();
            end
            overrun_clr = 1'b0;
            if ($urandom_range(0, 59) == 0) begin
                resetn = 1'b0;
                model_reset();
                #1;
                compare_all();
                step();
                resetn = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Absolute watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
